// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: default memory geometry and the load/dump engine state encoding.
package mips32_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } dump_state_t;

endpackage

// File: rtl/mips32_dump_fifo.sv
// Two-entry {addr, data} FIFO with registered head outputs for the memory dump stream.
module mips32_dump_fifo
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);

  logic [ADDR_W-1:0] tail_addr;
  logic [DATA_W-1:0] tail_data;

  // The head slot is the output register itself, so out_addr/out_data hold while stalled.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      head_addr <= '0;
      head_data <= '0;
      tail_addr <= '0;
      tail_data <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_addr <= push_addr;
            head_data <= push_data;
          end else begin
            tail_addr <= push_addr;
            tail_data <= push_data;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_addr <= tail_addr;
          head_data <= tail_data;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_addr <= push_addr;
            head_data <= push_data;
          end else begin
            head_addr <= tail_addr;
            head_data <= tail_data;
            tail_addr <= push_addr;
            tail_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  no_overflow : assert property (@(posedge clk1) disable iff (!rst_n)
    (push && !pop) |-> (occ < 2'd2));

  no_underflow : assert property (@(posedge clk1) disable iff (!rst_n)
    pop |-> (occ != 2'd0));

endmodule

// File: rtl/mips32_mem_dump.sv
// Post-halt data memory read-out: walks [base, base+count) and streams {addr, data} words.
module mips32_mem_dump
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  dump_state_t       state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   sent;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_addr;
  logic [1:0]        occ;
  logic [2:0]        level;
  logic              pop;
  logic              can_issue;

  assign pop       = out_valid & out_ready;
  assign out_valid = (occ != 2'd0);
  assign busy      = (state == RUN);
  assign done      = (state == FIN);

  // occ + inflight - pop < 2, rearranged to avoid an unsigned underflow.
  always_comb begin
    level     = {1'b0, occ} + {2'b00, inflight};
    can_issue = (state == RUN) && (issued < count_q) && (level < (3'd2 + {2'b00, pop}));
  end

  assign mem_rd_en   = can_issue;
  assign mem_rd_addr = (state == RUN) ? (base_q + issued[ADDR_W-1:0]) : '0;

  mips32_dump_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_addr (inflight_addr),
    .push_data (mem_rd_data),
    .pop       (pop),
    .occ       (occ),
    .head_addr (out_addr),
    .head_data (out_data)
  );

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state         <= IDLE;
      base_q        <= '0;
      count_q       <= '0;
      issued        <= '0;
      sent          <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else begin
      // Read data arrives one cycle after the strobe, so the address rides alongside it.
      inflight      <= can_issue;
      inflight_addr <= mem_rd_addr;
      if (can_issue) issued <= issued + 1'b1;
      if (pop) sent <= sent + 1'b1;
      case (state)
        IDLE: begin
          if (start && halted) begin
            base_q  <= base_addr;
            count_q <= count;
            issued  <= '0;
            sent    <= '0;
            state   <= (count == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (pop && (sent == count_q - 1'b1)) state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  issue_bounded : assert property (@(posedge clk1) disable iff (!rst_n)
    mem_rd_en |-> (level <= 3'd2));

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Self-checking bench for mips32_mem_dump: memory model, expected-word queue and per-cycle monitor.
module tb_mips32_mem_dump;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk1 = 1'b0;
  logic          rst_n, halted, start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          busy, done, mem_rd_en, out_valid, out_ready;
  logic [AW-1:0] mem_rd_addr, out_addr;
  logic [DW-1:0] mem_rd_data, out_data;

  mips32_mem_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .start(start),
    .base_addr(base_addr), .count(count), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk1 = ~clk1;

  logic [DW-1:0] mem [0:1023];
  always @(posedge clk1) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } word_t;
  word_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int rd_cnt, pend, first_valid, done_cnt, done_cyc, last_pop, pops;
  int unsigned m_base, m_count;
  int rdy_mode = 0;
  bit act_seen, prev_stall;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk1) cyc++;

  // out_ready pattern: always 1, the 1,0,0,1 cycle, or random.
  initial begin
    int pat = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk1);
      #1;
      case (rdy_mode)
        1:       begin out_ready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk1) begin
    if (!rst_n) begin
      exp_q.delete();
      rd_cnt = 0; pend = 0; prev_stall = 0;
    end else begin
      act_seen |= busy | done | out_valid | mem_rd_en;
      if (mem_rd_en) begin
        chk("rd_within_count", 64'(rd_cnt < int'(m_count)), 64'd1);
        chk("rd_addr", 64'(mem_rd_addr), 64'((m_base + rd_cnt) % 1024));
        rd_cnt++; pend++;
      end
      if (out_valid || mem_rd_en) chk("busy_when_active", 64'(busy), 64'd1);
      if (prev_stall) begin
        chk("stall_addr_stable", 64'(out_addr), 64'(prev_addr));
        chk("stall_data_stable", 64'(out_data), 64'(prev_data));
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) chk("unexpected_word", 64'(out_addr), 64'hFFFF);
        else begin
          chk("out_addr", 64'(out_addr), 64'(exp_q[0].a));
          chk("out_data", 64'(out_data), 64'(exp_q[0].d));
          if (out_ready) begin
            void'(exp_q.pop_front());
            pend--; pops++; last_pop = cyc;
          end
        end
      end
      if (pend > 2) chk("outstanding_le_2", 64'(pend), 64'd2);
      if (done) begin
        done_cnt++; done_cyc = cyc;
        chk("done_drained", 64'(exp_q.size()), 64'd0);
        if (last_pop >= 0) chk("done_after_last_pop", 64'(cyc), 64'(last_pop + 1));
      end
      prev_stall = out_valid && !out_ready;
      prev_addr = out_addr; prev_data = out_data;
    end
  end

  task automatic prep(input int unsigned b, input int unsigned n, input bit lit);
    m_base = b; m_count = n;
    if (!lit) begin
      exp_q.delete();
      for (int unsigned i = 0; i < n; i++) begin
        word_t w;
        w.a = AW'((b + i) % 1024);
        w.d = mem[(b + i) % 1024];
        exp_q.push_back(w);
      end
    end
    rd_cnt = 0; pend = 0; first_valid = -1; done_cnt = 0; done_cyc = -1;
    last_pop = -1; pops = 0; act_seen = 0;
  endtask

  task automatic run(input int unsigned b, input int unsigned n, input int mode,
                     input bit lit, input bit restart);
    int e0, budget;
    rdy_mode = mode;
    prep(b, n, lit);
    @(posedge clk1); #1;
    halted = 1'b1; start = 1'b1; base_addr = AW'(b); count = (AW+1)'(n);
    e0 = cyc + 1;
    @(posedge clk1); #1;
    start = 1'b0;
    budget = int'(n) * 8 + 50;
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      if (restart && k == 3) begin
        start = 1'b1; base_addr = AW'(b) ^ 10'h155; count = 11'd5;
      end else start = 1'b0;
      @(posedge clk1); #1;
    end
    start = 1'b0;
    if (done_cnt == 0) chk("run_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk1);
    #1;
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("all_words_out", 64'(exp_q.size()), 64'd0);
    chk("reads_issued", 64'(rd_cnt), 64'(n));
    if (mode == 0) begin
      if (n == 0) begin
        chk("done_cyc_cnt0", 64'(done_cyc), 64'(e0));
        chk("no_valid_cnt0", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("first_valid_lat", 64'(first_valid), 64'(e0 + 2));
        chk("done_cyc", 64'(done_cyc), 64'(e0 + 2 + int'(n)));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_addr"}, 64'(out_addr), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  initial begin
    word_t w;
    int wait_cyc;
    rst_n = 1'b0; halted = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    m_base = 0; m_count = 0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    prep(0, 0, 1);
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    check_zero("reset");
    @(posedge clk1); #1 rst_n = 1'b1;

    // literal two-word dump with ready held high
    mem[120] = 32'd85; mem[121] = 32'd130;
    exp_q.delete();
    w.a = 10'd120; w.d = 32'd85;  exp_q.push_back(w);
    w.a = 10'd121; w.d = 32'd130; exp_q.push_back(w);
    run(120, 2, 0, 1, 0);

    // start while not halted is ignored
    prep(120, 0, 0);
    @(posedge clk1); #1;
    halted = 1'b0; start = 1'b1; base_addr = 10'd120; count = 11'd2;
    @(posedge clk1); #1 start = 1'b0;
    repeat (10) @(posedge clk1);
    #1;
    chk("not_halted_idle", 64'(act_seen), 64'd0);
    chk("not_halted_no_done", 64'(done_cnt), 64'd0);

    // address wrap, data equals address
    for (int i = 0; i < 4; i++) mem[(1022 + i) % 1024] = 32'((1022 + i) % 1024);
    exp_q.delete();
    w.a = 10'd1022; w.d = 32'd1022; exp_q.push_back(w);
    w.a = 10'd1023; w.d = 32'd1023; exp_q.push_back(w);
    w.a = 10'd0;    w.d = 32'd0;    exp_q.push_back(w);
    w.a = 10'd1;    w.d = 32'd1;    exp_q.push_back(w);
    run(1022, 4, 0, 1, 0);

    run(500, 8, 1, 0, 0);
    run(300, 0, 0, 0, 0);

    // reset in the middle of a 16-word run
    rdy_mode = 0;
    prep(200, 16, 0);
    @(posedge clk1); #1;
    halted = 1'b1; start = 1'b1; base_addr = 10'd200; count = 11'd16;
    @(posedge clk1); #1 start = 1'b0;
    wait_cyc = 0;
    while (pops < 5 && wait_cyc < 100) begin
      @(posedge clk1); #1; wait_cyc++;
    end
    chk("reset_run_reached_5", 64'(pops), 64'd5);
    rst_n = 1'b0; m_count = 0;
    @(posedge clk1);
    @(negedge clk1);
    check_zero("abort");
    @(posedge clk1); #1 rst_n = 1'b1;
    act_seen = 0;
    repeat (5) @(posedge clk1);
    #1;
    chk("abort_quiet", 64'(act_seen), 64'd0);
    run(40, 6, 0, 0, 0);

    // randomized runs, including a start pulse mid-run that must be ignored
    run($urandom_range(0, 1023), 20, 2, 0, 1);
    for (int k = 0; k < 6; k++)
      run($urandom_range(0, 1023), $urandom_range(1, 40), k % 3, 0, 0);
    run(700, 1024, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips32_mem_dump.md
# mips32_mem_dump

Post-halt memory read-out engine for the pipelined MIPS32 core. Once the core raises HALTED, it walks a contiguous word range of data memory through a synchronous read port and streams each word with its address over a valid/ready interface toward a host, log sink or checker. It replaces hierarchical peeking at `Mem[]` with a synthesizable, back-pressurable dump path. It is the read-back counterpart of the program/data load path.

## Interface
Parameters:
- `ADDR_W`, 10, memory word-address width (1024 words)
- `DATA_W`, 32, memory word width

Ports:
- `clk1`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `halted`  in  1  core HALTED flag; `start` is accepted only when it is 1
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_addr`  in  ADDR_W  first word address; latched when `start` is accepted
- `count`  in  ADDR_W+1  number of words to dump, 0..2^ADDR_W; latched when `start` is accepted
- `busy`  out  1  high from the cycle after an accepted start until the last word handshake
- `done`  out  1  one-cycle pulse after the run completes
- `mem_rd_en`  out  1  read strobe to memory
- `mem_rd_addr`  out  ADDR_W  read address
- `mem_rd_data`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd_en`
- `out_valid`  out  1  stream word available
- `out_ready`  in  1  sink accepts the word
- `out_addr`  out  ADDR_W  address of the current stream word
- `out_data`  out  DATA_W  current stream word

## Operation
- States: IDLE, RUN, FIN.
- IDLE -> RUN: `start & halted & (count != 0)` at an edge. Latch base and count. Clear the issued and sent counters.
- IDLE -> FIN: `start & halted & (count == 0)`. No read is issued and no word is emitted.
- `start` with `halted = 0`, or `start` in RUN or FIN, is ignored.
- RUN issues reads into a 2-entry output FIFO. Each FIFO entry holds {addr, data}.
- A read issues in a cycle when both conditions hold:
  - `issued < count`
  - `occ + inflight - pop < 2`, where `pop = out_valid & out_ready` in that cycle.
- Issue addresses are `base + issued`, taken mod 2^ADDR_W, so reads wrap from 1023 to 0.
- At most 1 read is in flight (1-cycle latency). The returning data is written into the FIFO on the following edge.
- Stream outputs: `out_valid = (occ != 0)`. `out_addr` and `out_data` come from the FIFO head. Both stay stable while `out_valid & !out_ready`.
- RUN -> FIN: on the edge where `pop` occurs with `sent == count - 1`.
- FIN -> IDLE unconditionally after 1 cycle. `done = 1` only in FIN.
- `busy = (state == RUN)`.
- Reset values: state IDLE. All counters, occupancy and in-flight flag cleared. `busy`, `done`, `mem_rd_en`, `out_valid` = 0. `mem_rd_addr`, `out_addr`, `out_data` = 0.
- Reset during RUN aborts immediately. A returning read in flight at reset is discarded, and no word is emitted after reset.
- Counter widths are ADDR_W+1 so that `count = 1024` is representable.

## Timing
- `mem_rd_en` and `mem_rd_addr` are combinational from registered state and counters only. There is no combinational path from `out_ready` except through the `pop` term in the issue condition.
- Start accepted at edge E0 (all edges below counted from E0):
  - `mem_rd_en` with `base` is high in the cycle after E0.
  - The data is written into the FIFO at E2.
  - `out_valid` first rises in the cycle after E2.
- With `out_ready` held at 1: one word per cycle, N words occupy N consecutive cycles, and `done` pulses in the cycle after the last handshake.
- Back-pressure: while `out_ready = 0`, issue stalls once `occ + inflight = 2`. No word is dropped or duplicated.

## Structure
- A shared package `mips32_pkg` holds `ADDR_W`/`DATA_W` defaults and the state enum {IDLE, RUN, FIN}. These are shared with the load-side block.
- One natural sub-module, `mips32_dump_fifo`: a 2-entry {addr, data} FIFO with push, pop, occupancy, and registered head outputs.
- The top level holds the FSM, the counters and the issue logic.

## Test plan
- Preload `Mem[120] = 85`, `Mem[121] = 130`; set halted = 1; start with base = 120, count = 2; hold `out_ready = 1` -> stream (120, 85), (121, 130) on consecutive cycles, first `out_valid` 3 cycles after start, then `done` pulses once.
- Same run with halted = 0 at start -> `busy`, `mem_rd_en`, `out_valid` and `done` stay 0.
- base = 1022, count = 4, `Mem[k] = k` -> addresses 1022, 1023, 0, 1 with matching data.
- count = 8; `out_ready` toggles 1, 0, 0, 1 repeatedly -> all 8 words emitted in order, outputs stable while stalled, never more than 2 reads outstanding plus buffered.
- count = 0 -> `done` pulses in the cycle after start, with no read and no `out_valid`.
- count = 16, reset asserted after 5 handshakes -> all outputs 0 on the next cycle; a new start then dumps from the new base.
